spi_eeprom_responder: RTL and testbench
=======================================

// Module: spi_eeprom_responder
// PURPOSE
// - Synthesizable SPI slave modelled on a 25xx-series EEPROM; it is the far end of the SPI link that the AXI-Lite SPI master drives.
// - Decodes READ/WRITE/WREN/WRDI/RDSR/WRSR and serves a small on-chip byte array.
// - Provides a self-checking loop-back target for AXI-SPI bring-up on FPGA, where the behavioural EEPROM model cannot be used.
// PARAMETERS
// - ADDR_W        11    address bits used (upper bits of the 16-bit SPI address are ignored); depth = 2**ADDR_W
// - PAGE_W        4     page size = 2**PAGE_W bytes; WRITE address wraps within the page
// - WRITE_CYCLES  1000  ACLK cycles for which WIP stays set after a committed WRITE/WRSR
// PORTS
// - ACLK      in   1  system clock; all logic is on its rising edge
// - RESET     in   1  asynchronous, active-high reset
// - SPI_SCK   in   1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to ACLK
// - SPI_CSn   in   1  chip select, active low
// - SPI_MOSI  in   1  serial data in, MSB first
// - SPI_MISO  out  1  serial data out, MSB first
// - MISO_OE   out  1  1 = drive SPI_MISO; the top level tri-states the pin when this is 0
// - WP_N      in   1  write protect, active low
// - BUSY      out  1  mirror of the status WIP bit
// BEHAVIOUR
// Reset values: SPI_MISO=0, MISO_OE=0, BUSY=0, status=8'h00, FSM=IDLE. Memory contents are not reset.
// Input sampling and SCK timing
// - SCK, CSn and MOSI pass through 2-FF synchronisers; edges are detected on the synchronised SCK.
// - Required ratio: f(SCK) <= f(ACLK)/8.
// - MOSI is sampled on a synchronised SCK rise, 3 ACLK cycles after the pin edge.
// - SPI_MISO changes within 3 ACLK cycles after a synchronised SCK fall.
// Chip select
// - CSn falling edge: clear bit counter, enter CMD, assert MISO_OE.
// - CSn high: FSM returns to IDLE and MISO_OE=0 on the next ACLK.
// - A CSn rise in any state aborts the transaction; a partially shifted byte is discarded.
// FSM states: IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, RDSR, WRSR, IGNORE.
// - CMD: after 8 rises, decode the opcode.
//   - 8'h06 -> WEL=1, go to IGNORE.
//   - 8'h04 -> WEL=0, go to IGNORE.
//   - 8'h05 -> go to RDSR.
//   - 8'h01 -> go to WRSR.
//   - 8'h03 or 8'h02 -> go to ADDR_HI.
//   - Any other opcode, or any opcode while WIP=1 except RDSR -> go to IGNORE.
// - ADDR_HI and ADDR_LO: 8 bits each, forming a 16-bit address; the low ADDR_W bits are kept.
// - RD_DATA
//   - On rise 24, load the shift register with mem[addr]; its MSB appears on SPI_MISO after fall 24.
//   - Every 8 bits, addr increments and the next byte is loaded; addr wraps from 2**ADDR_W-1 to 0.
// - WR_DATA
//   - Allowed only if WEL=1 and WP_N=1; otherwise behave as IGNORE.
//   - Each complete byte is written to mem[addr] on its 8th rise.
//   - Only addr[PAGE_W-1:0] increments, wrapping inside the page.
// - RDSR: shift out status {WPEN,3'b0,BP1,BP0,WEL,WIP}, repeating for as long as SCK runs.
// - WRSR: requires WEL=1 and WP_N=1; on the 8th data rise, store bits 7, 3 and 2. BP bits are stored but not enforced.
// - Commit: on a CSn rise at a byte boundary (bit count mod 8 == 0) after at least one data byte in WR_DATA or WRSR:
//   - set WIP, clear WEL, load a down-counter with WRITE_CYCLES;
//   - WIP clears when the counter reaches 0.
// - Unqualified CSn rise in WR_DATA or WRSR (not on a byte boundary, or with no data byte): WEL and WIP are unchanged.
// - IGNORE: SPI_MISO=0 until CSn rises.
// - RESET mid-transfer: immediate return to reset values; any write in progress is not completed.
// STRUCTURE
// - Shared package/header: opcode constants, status bit indices, FSM state encodings.
// - Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall pulse generator. Instantiate it for SCK and CSn; MOSI uses the synchroniser only.
// - Memory: inferred single-port RAM, 2**ADDR_W x 8.
// TESTING (AXI master side: SPI_SCK = ACLK/16, base address 32'hFFFF0000)
// - WREN; WRITE 8'h02, 16'h00F0, 8'hAA; poll RDSR until 8'h00; READ 16'h00F0 -> SPI_MISO shifts 8'hAA, and BUSY pulses for WRITE_CYCLES.
// - WRITE to 16'h0010 with no preceding WREN -> memory unchanged; RDSR returns 8'h00.
// - WREN; WRITE 16'h00F0 with 17 bytes 8'h00..8'h10 -> the last byte overwrites 16'h00F0 (reads back 8'h10); 16'h0100 is untouched.
// - READ from 16'h07FF (2**ADDR_W-1) for 2 bytes -> second byte = mem[0].
// - WREN; WRITE with CSn raised after 4 data bits -> no commit, WIP stays 0, WEL stays 1; a WREN followed by an immediate RDSR in the same frame is not possible.
// - RESET asserted mid-READ -> SPI_MISO=0, MISO_OE=0, BUSY=0 in the same cycle; the next READ frame behaves normally.

Source files
------------

// File: rtl/spi_eeprom_responder_pkg.sv
// Opcodes, status bit positions and FSM encoding for the 25xx-style SPI EEPROM responder.
package spi_eeprom_responder_pkg;

  localparam logic [7:0] OpWrsr  = 8'h01;
  localparam logic [7:0] OpWrite = 8'h02;
  localparam logic [7:0] OpRead  = 8'h03;
  localparam logic [7:0] OpWrdi  = 8'h04;
  localparam logic [7:0] OpRdsr  = 8'h05;
  localparam logic [7:0] OpWren  = 8'h06;

  localparam int unsigned StatWip  = 0;
  localparam int unsigned StatWel  = 1;
  localparam int unsigned StatBp0  = 2;
  localparam int unsigned StatBp1  = 3;
  localparam int unsigned StatWpen = 7;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddrHi,
    StAddrLo,
    StRdData,
    StWrData,
    StRdsr,
    StWrsr,
    StIgnore
  } state_e;

endpackage

// File: rtl/spi_eeprom_responder_sync_edge.sv
// 2-FF synchroniser for an asynchronous SPI pin with single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
      prev_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 slave behaving like a small 25xx EEPROM, used as a loop-back target for SPI bring-up.
module spi_eeprom_responder
  import spi_eeprom_responder_pkg::*;
#(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned PAGE_W       = 4,
  parameter int unsigned WRITE_CYCLES = 1000
) (
  input  logic ACLK,
  input  logic RESET,
  input  logic SPI_SCK,
  input  logic SPI_CSn,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  output logic MISO_OE,
  input  logic WP_N,
  output logic BUSY
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = $clog2(WRITE_CYCLES + 1);

  state_e              state_q, state_d;
  logic                sck_rise, sck_fall, csn_rise, csn_fall;
  logic                mosi_meta_q, mosi_q;
  logic [2:0]          bit_cnt_q;
  logic [6:0]          shift_in_q;
  logic [7:0]          shift_out_q, rx_byte, status, ram_rdata_q;
  logic                miso_q, is_write_q, data_seen_q;
  logic [1:0]          load_q;
  logic [ADDR_W-9:0]   addr_hi_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wel_q, wpen_q, bp1_q, bp0_q;
  logic [CntW-1:0]     wip_cnt_q;
  logic                wip, wr_ok, byte_done, commit, mem_we;
  logic [7:0]          mem [Depth];

  spi_sync_edge #(.ResetVal(1'b0)) u_sck_sync (
    .clk_i  (ACLK),
    .rst_i  (RESET),
    .d_i    (SPI_SCK),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.ResetVal(1'b1)) u_csn_sync (
    .clk_i  (ACLK),
    .rst_i  (RESET),
    .d_i    (SPI_CSn),
    .rise_o (csn_rise),
    .fall_o (csn_fall)
  );

  // Same depth as the SCK synchroniser so MOSI is stable when the rise pulse fires.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      mosi_meta_q <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      mosi_meta_q <= SPI_MOSI;
      mosi_q      <= mosi_meta_q;
    end
  end

  assign rx_byte   = {shift_in_q, mosi_q};
  assign wip       = (wip_cnt_q != '0);
  assign wr_ok     = wel_q & WP_N;
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7) && (state_q != StIdle);
  assign mem_we    = byte_done && (state_q == StWrData);
  assign commit    = csn_rise && ((state_q == StWrData) || (state_q == StWrsr)) &&
                     (bit_cnt_q == 3'd0) && data_seen_q;

  always_comb begin
    status           = 8'h00;
    status[StatWpen] = wpen_q;
    status[StatBp1]  = bp1_q;
    status[StatBp0]  = bp0_q;
    status[StatWel]  = wel_q;
    status[StatWip]  = wip;
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (csn_rise) begin
      state_d = StIdle;
    end else if (csn_fall) begin
      state_d = StCmd;
    end else if (byte_done) begin
      case (state_q)
        StCmd: begin
          if (wip && (rx_byte != OpRdsr)) begin
            state_d = StIgnore;
          end else begin
            case (rx_byte)
              OpRdsr:          state_d = StRdsr;
              OpWrsr:          state_d = wr_ok ? StWrsr : StIgnore;
              OpRead, OpWrite: state_d = StAddrHi;
              default:         state_d = StIgnore;
            endcase
          end
        end
        StAddrHi: state_d = StAddrLo;
        StAddrLo: state_d = is_write_q ? (wr_ok ? StWrData : StIgnore) : StRdData;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    MISO_OE  = (state_q != StIdle);
    SPI_MISO = miso_q;
    BUSY     = wip;
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      miso_q      <= 1'b0;
      is_write_q  <= 1'b0;
      data_seen_q <= 1'b0;
      load_q      <= '0;
      addr_hi_q   <= '0;
      addr_q      <= '0;
      wel_q       <= 1'b0;
      wpen_q      <= 1'b0;
      bp1_q       <= 1'b0;
      bp0_q       <= 1'b0;
      wip_cnt_q   <= '0;
    end else begin
      load_q <= {load_q[0], 1'b0};
      if (wip) begin
        wip_cnt_q <= wip_cnt_q - 1'b1;
      end
      if (csn_fall) begin
        bit_cnt_q   <= '0;
        shift_out_q <= '0;
        miso_q      <= 1'b0;
        data_seen_q <= 1'b0;
        load_q      <= '0;
      end else if (state_q == StIdle) begin
        miso_q <= 1'b0;
      end else begin
        if (sck_fall) begin
          miso_q      <= shift_out_q[7];
          shift_out_q <= {shift_out_q[6:0], 1'b0};
        end
        // Read data arrives two cycles after the address update; SCK is slow enough for that.
        if (load_q[1] && (state_q == StRdData)) begin
          shift_out_q <= ram_rdata_q;
        end
        if (sck_rise) begin
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          shift_in_q <= rx_byte[6:0];
        end
        if (byte_done) begin
          case (state_q)
            StCmd: begin
              is_write_q <= (rx_byte == OpWrite);
              if (!wip && (rx_byte == OpWren)) wel_q <= 1'b1;
              if (!wip && (rx_byte == OpWrdi)) wel_q <= 1'b0;
              if (rx_byte == OpRdsr) shift_out_q <= status;
            end
            StAddrHi: addr_hi_q <= rx_byte[ADDR_W-9:0];
            StAddrLo: begin
              addr_q <= {addr_hi_q, rx_byte};
              load_q <= 2'b01;
            end
            StRdData: begin
              addr_q <= addr_q + 1'b1;
              load_q <= 2'b01;
            end
            StWrData: begin
              addr_q      <= {addr_q[ADDR_W-1:PAGE_W], addr_q[PAGE_W-1:0] + 1'b1};
              data_seen_q <= 1'b1;
            end
            StRdsr: shift_out_q <= status;
            StWrsr: begin
              wpen_q      <= rx_byte[StatWpen];
              bp1_q       <= rx_byte[StatBp1];
              bp0_q       <= rx_byte[StatBp0];
              data_seen_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (commit) begin
        wel_q     <= 1'b0;
        wip_cnt_q <= CntW'(WRITE_CYCLES);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      mem[addr_q] <= rx_byte;
    end
    ram_rdata_q <= mem[addr_q];
  end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Randomised bench for spi_eeprom_responder against a byte-array model of a 25xx EEPROM.
module tb_spi_eeprom_responder;

  localparam int unsigned ADDR_W       = 11;
  localparam int unsigned PAGE_W       = 4;
  localparam int unsigned WRITE_CYCLES = 1000;
  localparam int          DEPTH        = 1 << ADDR_W;
  localparam int          PAGE         = 1 << PAGE_W;
  localparam int          HALF         = 8;

  logic ACLK = 1'b0;
  logic RESET = 1'b0;
  logic SPI_SCK = 1'b0;
  logic SPI_CSn = 1'b1;
  logic SPI_MOSI = 1'b0;
  logic WP_N = 1'b1;
  logic SPI_MISO, MISO_OE, BUSY;

  always #5 ACLK = ~ACLK;

  spi_eeprom_responder #(
    .ADDR_W       (ADDR_W),
    .PAGE_W       (PAGE_W),
    .WRITE_CYCLES (WRITE_CYCLES)
  ) dut (
    .ACLK     (ACLK),
    .RESET    (RESET),
    .SPI_SCK  (SPI_SCK),
    .SPI_CSn  (SPI_CSn),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .MISO_OE  (MISO_OE),
    .WP_N     (WP_N),
    .BUSY     (BUSY)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  bit         m_wel, m_wpen, m_bp1, m_bp0;

  logic       rx_bit;
  logic [7:0] rx_last;
  logic [7:0] wq [$];

  int busy_run = 0;
  int last_pulse = 0;

  always @(negedge ACLK) begin
    if (BUSY === 1'b1) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_pulse <= busy_run;
      busy_run   <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_wpen, 3'b000, m_bp1, m_bp0, m_wel, 1'b0};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic cs_low();
    SPI_CSn = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    SPI_CSn = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic spi_bit(input logic tx);
    SPI_MOSI = tx;
    wait_clk(HALF);
    rx_bit = SPI_MISO;
    SPI_SCK = 1'b1;
    wait_clk(HALF);
    SPI_SCK = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [7:0] r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i]);
      r[i] = rx_bit;
    end
    rx_last = r;
  endtask

  task automatic op_only(input logic [7:0] op);
    cs_low();
    spi_byte(op);
    cs_high();
    if (op == 8'h06) m_wel = 1'b1;
    if (op == 8'h04) m_wel = 1'b0;
  endtask

  task automatic rdsr_raw(output logic [7:0] st);
    cs_low();
    spi_byte(8'h05);
    spi_byte(8'h00);
    st = rx_last;
    cs_high();
  endtask

  task automatic rdsr_check(input string tag);
    cs_low();
    spi_byte(8'h05);
    spi_byte(8'h00);
    check(tag, rx_last, m_status());
    spi_byte(8'h00);
    check({tag, "_rep"}, rx_last, m_status());
    cs_high();
  endtask

  task automatic poll_idle();
    logic [7:0] st;
    int n;
    n = 0;
    do begin
      rdsr_raw(st);
      n++;
    end while (st[0] !== 1'b0 && n < 50);
    check("poll_idle_status", st, m_status());
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data [$], input bit wait_idle);
    int base, a;
    bit ok;
    ok = m_wel && (WP_N == 1'b1);
    cs_low();
    spi_byte(8'h02);
    spi_byte(addr[15:8]);
    spi_byte(addr[7:0]);
    foreach (data[i]) spi_byte(data[i]);
    cs_high();
    if (ok && data.size() > 0) begin
      base = int'(addr) % DEPTH;
      foreach (data[i]) begin
        a = (base & ~(PAGE - 1)) | ((base + i) & (PAGE - 1));
        m_mem[a]   = data[i];
        m_known[a] = 1'b1;
      end
      m_wel = 1'b0;
      check("busy_after_commit", BUSY, 1);
      if (wait_idle) poll_idle();
    end
  endtask

  task automatic wren_write1(input logic [15:0] addr, input logic [7:0] val);
    op_only(8'h06);
    wq = {};
    wq.push_back(val);
    do_write(addr, wq, 1'b1);
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr, input int n);
    int a;
    cs_low();
    spi_byte(8'h03);
    spi_byte(addr[15:8]);
    spi_byte(addr[7:0]);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'h00);
      a = (int'(addr) + i) % DEPTH;
      if (m_known[a]) check(tag, rx_last, m_mem[a]);
    end
    cs_high();
  endtask

  task automatic do_wrsr(input logic [7:0] v);
    bit ok;
    ok = m_wel && (WP_N == 1'b1);
    cs_low();
    spi_byte(8'h01);
    spi_byte(v);
    cs_high();
    if (ok) begin
      m_wpen = v[7];
      m_bp1  = v[3];
      m_bp0  = v[2];
      m_wel  = 1'b0;
      check("busy_after_wrsr", BUSY, 1);
      poll_idle();
    end
  endtask

  task automatic pulse_reset();
    @(negedge ACLK);
    RESET = 1'b1;
    #1;
    check("rst_miso", SPI_MISO, 0);
    check("rst_oe", MISO_OE, 0);
    check("rst_busy", BUSY, 0);
    SPI_CSn  = 1'b1;
    SPI_SCK  = 1'b0;
    SPI_MOSI = 1'b0;
    wait_clk(4);
    RESET = 1'b0;
    wait_clk(4);
    m_wel  = 1'b0;
    m_wpen = 1'b0;
    m_bp1  = 1'b0;
    m_bp0  = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    int len;
    logic [7:0] v;

    wait_clk(2);
    pulse_reset();
    rdsr_check("status_after_reset");

    // Basic write/poll/read and WIP pulse length.
    wren_write1(16'h00F0, 8'hAA);
    check("busy_pulse_len", last_pulse, WRITE_CYCLES);
    do_read("read_f0", 16'h00F0, 1);

    wren_write1(16'h0010, 8'h5A);
    wren_write1(16'h0100, 8'h77);
    wren_write1(16'h0000, 8'h3C);
    wren_write1(16'h07FF, 8'hC3);
    wren_write1(16'h0020, 8'hE1);
    wren_write1(16'h0030, 8'h1E);

    // Write without WREN is ignored.
    wq = {};
    wq.push_back(8'h99);
    do_write(16'h0010, wq, 1'b1);
    check("no_wren_busy", BUSY, 0);
    rdsr_check("no_wren_status");
    do_read("no_wren_read", 16'h0010, 1);

    // 17-byte page write wraps within the page.
    op_only(8'h06);
    wq = {};
    for (int i = 0; i < 17; i++) wq.push_back(8'(i));
    do_write(16'h00F0, wq, 1'b1);
    check("page_wrap_model", m_mem[16'h00F0], 8'h10);
    do_read("page_wrap_read", 16'h00F0, 16);
    do_read("page_next_untouched", 16'h0100, 1);

    // Read wraps from the top of the array to address 0; upper address bits ignored.
    do_read("addr_wrap", 16'h07FF, 2);
    do_read("addr_alias", 16'hF800, 1);

    // Aborted write after 4 data bits: no commit.
    op_only(8'h06);
    cs_low();
    spi_byte(8'h02);
    spi_byte(8'h00);
    spi_byte(8'h20);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    cs_high();
    check("abort_busy", BUSY, 0);
    rdsr_check("abort_status");
    do_read("abort_read", 16'h0020, 1);
    op_only(8'h04);
    rdsr_check("wrdi_status");

    // Write protect pin blocks writes.
    WP_N = 1'b0;
    op_only(8'h06);
    wq = {};
    wq.push_back(8'h55);
    do_write(16'h0030, wq, 1'b1);
    rdsr_check("wp_status");
    do_read("wp_read", 16'h0030, 1);
    WP_N = 1'b1;
    op_only(8'h04);

    // Status register writes.
    do_wrsr(8'hFF);
    rdsr_check("wrsr_no_wel");
    v = 8'($urandom);
    op_only(8'h06);
    do_wrsr(v);
    rdsr_check("wrsr_rand");
    op_only(8'h06);
    do_wrsr(8'h00);

    // Randomised writes and reads.
    for (int it = 0; it < 6; it++) begin
      ra  = 16'($urandom);
      len = int'($urandom_range(1, 5));
      wq  = {};
      for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
      op_only(8'h06);
      do_write(ra, wq, 1'b1);
      do_read("rand_read", ra, len);
      do_read("rand_reread", 16'h00F0, 2);
    end

    // Reset while busy, inside an RDSR frame.
    op_only(8'h06);
    wq = {};
    wq.push_back(8'hFF);
    do_write(16'h0040, wq, 1'b0);
    cs_low();
    spi_byte(8'h05);
    for (int i = 0; i < 3; i++) spi_bit(1'b0);
    check("pre_rst_busy", BUSY, 1);
    check("pre_rst_oe", MISO_OE, 1);
    pulse_reset();
    rdsr_check("post_rst1_status");

    // Reset mid-READ while MISO is high.
    cs_low();
    spi_byte(8'h03);
    spi_byte(8'h00);
    spi_byte(8'h40);
    spi_bit(1'b0);
    spi_bit(1'b0);
    wait_clk(HALF);
    check("pre_rst_miso", SPI_MISO, 1);
    check("pre_rst_oe2", MISO_OE, 1);
    pulse_reset();
    do_read("post_rst_read", 16'h0040, 2);
    rdsr_check("final_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
